store_buffer: RTL and testbench

Word-granular posted-write buffer between the CPU memory stage and `datamem`. Stores are accepted in one cycle and queued in a small FIFO. The queue drains into `datamem` one word per cycle whenever the memory port is not needed by a load. Loads go straight to `datamem`, but any address still pending in the buffer is forwarded from the buffer so the CPU always sees the most recent store.

---
 rtl/store_buffer.sv | 142 ++++++++++++++
 tb/tb_store_buffer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between the CPU memory stage and datamem.
// Stores are queued in a DEPTH-entry circular FIFO. The queue drains one word
// per cycle into datamem whenever no load needs the port. Loads bypass the queue,
// but any pending store to the same word is forwarded, youngest first.
// Optional feature: define STBUF_COALESCE_EN to merge a store into an existing
// entry for the same word instead of allocating a new one.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] adr,
    input  logic [31:0] writedata,
    input  logic        MR,
    input  logic        MW,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        empty,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    output logic        mem_MR,
    output logic        mem_MW,
    input  logic [31:0] mem_rdata
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [29:0]      word_reg [DEPTH];
    logic [31:0]      data_reg [DEPTH];
    logic [DEPTH-1:0] valid_reg, valid_next;
    logic [AW-1:0]    head_reg, tail_reg;
    logic [AW:0]      count_reg;

    logic [DEPTH-1:0] match;
    logic             full;
    logic             coalesce_hit;
    logic             in_place;
    logic             do_store;
    logic             alloc;
    logic             drain;
    logic             fwd_hit;
    logic [AW-1:0]    fwd_idx;

    // Per-entry word-address compare, shared by coalescing and forwarding.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = valid_reg[gi] && (word_reg[gi] == adr[31:2]);
        end
    endgenerate

    assign full  = (count_reg == FULL_CNT);
    assign empty = (count_reg == '0);

`ifdef STBUF_COALESCE_EN
    logic [AW-1:0] hit_idx;

    // Locate the (unique) entry already holding this word.
    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match[i]) hit_idx = AW'(i);
        end
    end

    assign coalesce_hit = |match;
    // Merging into the head while it drains would lose the new data, so that
    // case allocates a fresh entry instead (the popped slot makes room).
    assign in_place = do_store && coalesce_hit && !(drain && hit_idx == head_reg);
`else
    assign coalesce_hit = 1'b0;
    assign in_place     = 1'b0;
`endif

    assign stall    = MW && full && !coalesce_hit;
    assign do_store = MW && !stall && (adr != 32'd0);
    assign alloc    = do_store && !in_place;
    assign drain    = !empty && !MR;

    // Forwarding: walk from oldest (head) to youngest so the last match wins.
    always_comb begin
        logic [AW-1:0] idx;
        fwd_hit = 1'b0;
        fwd_idx = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_reg + i[AW-1:0];
            if (match[idx]) begin
                fwd_hit = 1'b1;
                fwd_idx = idx;
            end
        end
    end

    assign readdata = fwd_hit ? data_reg[fwd_idx] : mem_rdata;

    // Memory port: loads own it; otherwise it idles on / drains the head entry.
    assign mem_MR    = MR;
    assign mem_MW    = drain && !rst;
    assign mem_adr   = MR ? {adr[31:2], 2'b00} : {word_reg[head_reg], 2'b00};
    assign mem_wdata = data_reg[head_reg];

    // Valid bits: clear the popped head first so a same-slot allocate survives.
    always_comb begin
        valid_next = valid_reg;
        if (drain) valid_next[head_reg] = 1'b0;
        if (alloc) valid_next[tail_reg] = 1'b1;
    end

    // Pointer, count and valid state; reset drops every pending store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_next;
            if (drain) head_reg <= head_reg + PTR_ONE;
            if (alloc) tail_reg <= tail_reg + PTR_ONE;
            case ({alloc, drain})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Entry storage: allocate at the tail, or overwrite a coalesced entry.
    always_ff @(posedge clk) begin
`ifdef STBUF_COALESCE_EN
        if (in_place) begin
            data_reg[hit_idx] <= writedata;
        end
`endif
        if (alloc) begin
            word_reg[tail_reg] <= adr[31:2];
            data_reg[tail_reg] <= writedata;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed checks of store_buffer (DEPTH=4) with a write log
// standing in for datamem; datamem read data is a fixed function of address.
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr, writedata, readdata, mem_adr, mem_wdata, mem_rdata;
    logic        MR, MW, stall, empty, mem_MR, mem_MW;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] wq[$];

    store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .adr(adr), .writedata(writedata),
        .MR(MR), .MW(MW), .readdata(readdata), .stall(stall), .empty(empty),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_MR(mem_MR),
        .mem_MW(mem_MW), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = 32'hD000_0000 | {2'b00, mem_adr[31:2]};

    // Record every write datamem would commit at this edge.
    always @(posedge clk) begin
        if (mem_MW) begin
            wq.push_back({mem_adr, mem_wdata});
            $display("datamem write adr=%h data=%h", mem_adr, mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mr, input logic mw, input logic [31:0] a, input logic [31:0] d);
        MR = mr; MW = mw; adr = a; writedata = d;
        #1;
    endtask

    task automatic drain_all();
        MR = 1'b0; MW = 1'b0;
        for (int k = 0; k < 20 && !empty; k++) tick();
        chk("drain_empty", {63'd0, empty}, 64'd1);
    endtask

    initial begin
        rst = 1'b1; MR = 1'b1; MW = 1'b0; adr = 32'h40; writedata = '0;
        #1;
        chk("rst_empty", {63'd0, empty}, 64'd1);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_memMW", {63'd0, mem_MW}, 64'd0);
        chk("rst_memMR", {63'd0, mem_MR}, 64'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single store, drained in the following idle cycle.
        drive(1'b0, 1'b1, 32'h10, 32'h11);
        chk("t1_stall", {63'd0, stall}, 64'd0);
        chk("t1_memMW_pre", {63'd0, mem_MW}, 64'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("t1_memMW", {63'd0, mem_MW}, 64'd1);
        chk("t1_memadr", {32'd0, mem_adr}, 64'h10);
        chk("t1_memwdata", {32'd0, mem_wdata}, 64'h11);
        tick();
        chk("t1_empty", {63'd0, empty}, 64'd1);
        chk("t1_log", (wq.size() == 1) ? wq[0] : 64'hX, {32'h10, 32'h11});
        wq.delete();

        // Five stores; the first four coincide with loads so nothing drains.
        drive(1'b1, 1'b1, 32'h100, 32'd1);
        chk("t2_ld_before", {32'd0, readdata}, {32'd0, 32'hD000_0040});
        chk("t2_noMW_load", {63'd0, mem_MW}, 64'd0);
        tick();
        for (int k = 1; k < 4; k++) begin
            drive(1'b1, 1'b1, 32'h100 + 32'(4 * k), 32'(k + 1));
            tick();
        end
        drive(1'b1, 1'b1, 32'h110, 32'd5);
        chk("t2_stall_full", {63'd0, stall}, 64'd1);
        tick();
        drive(1'b0, 1'b1, 32'h110, 32'd5);
        chk("t2_stall_drain", {63'd0, stall}, 64'd1);
        chk("t2_drain_adr", {32'd0, mem_adr}, 64'h100);
        tick();
        chk("t2_accept", {63'd0, stall}, 64'd0);
        chk("t2_drain2_adr", {32'd0, mem_adr}, 64'h104);
        tick();
        drain_all();
        chk("t2_nwrites", 64'(wq.size()), 64'd5);
        for (int k = 0; k < 5 && k < wq.size(); k++)
            chk("t2_order", wq[k], {32'h100 + 32'(4 * k), 32'(k + 1)});
        wq.delete();

        // Forwarding picks the youngest of two stores to the same word.
        drive(1'b0, 1'b1, 32'h20, 32'hAA);
        tick();
        drive(1'b1, 1'b1, 32'h20, 32'hBB);
        chk("t3_ld_same_cycle", {32'd0, readdata}, 64'hAA);
        tick();
        drive(1'b1, 1'b0, 32'h20, 32'h0);
        chk("t3_fwd", {32'd0, readdata}, 64'hBB);
        chk("t3_memMW", {63'd0, mem_MW}, 64'd0);
        chk("t3_memadr", {32'd0, mem_adr}, 64'h20);
        drive(1'b1, 1'b0, 32'h24, 32'h0);
        chk("t3_miss", {32'd0, readdata}, {32'd0, 32'hD000_0009});
        drain_all();
        chk("t3_last", (wq.size() > 0) ? wq[wq.size() - 1] : 64'hX, {32'h20, 32'hBB});
        wq.delete();

        // Store to address 0 is dropped silently.
        drive(1'b0, 1'b1, 32'h0, 32'hFF);
        chk("t4_stall", {63'd0, stall}, 64'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("t4_empty", {63'd0, empty}, 64'd1);
        chk("t4_memMW", {63'd0, mem_MW}, 64'd0);
        tick();
        chk("t4_nwrites", 64'(wq.size()), 64'd0);

        // Reset in the middle of a drain cycle.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 32'h30 + 32'(4 * k), 32'h50 + 32'(k));
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("t5_memMW_pre", {63'd0, mem_MW}, 64'd1);
        chk("t5_adr_pre", {32'd0, mem_adr}, 64'h30);
        #2 rst = 1'b1;
        #1;
        chk("t5_memMW_rst", {63'd0, mem_MW}, 64'd0);
        chk("t5_empty_rst", {63'd0, empty}, 64'd1);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("t5_nwrites", 64'(wq.size()), 64'd0);
        chk("t5_empty", {63'd0, empty}, 64'd1);

`ifdef STBUF_COALESCE_EN
        // Coalescing: a store to a held word merges even when full.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 32'h200 + 32'(4 * k), 32'hA0 + 32'(k));
            tick();
        end
        drive(1'b1, 1'b1, 32'h208, 32'h77);
        chk("t6_nostall", {63'd0, stall}, 64'd0);
        chk("t6_fwd_old", {32'd0, readdata}, 64'hA2);
        tick();
        drive(1'b1, 1'b1, 32'h210, 32'h99);
        chk("t6_still_full", {63'd0, stall}, 64'd1);
        drain_all();
        chk("t6_nwrites", 64'(wq.size()), 64'd4);
        chk("t6_merged", (wq.size() == 4) ? wq[2] : 64'hX, {32'h208, 32'h77});
        wq.delete();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
